// File: rtl/snake_display_pkg.sv
// Shared constants and helpers for the multi-digit snake display.
// Path geometry lives here so the decoder and the top agree on it.
package snake_display_pkg;

    // Segment bit positions inside a {a..g} vector (a is the MSB).
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Ring length: top row, right pair, bottom row, left pair.
    function automatic int path_len(input int n);
        return 2 * n + 4;
    endfunction

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Segment lit by ring position k on an n-digit display.
    function automatic int seg_of(input int k, input int n);
        if (k < n)              return SEG_A;
        else if (k == n)        return SEG_B;
        else if (k == n + 1)    return SEG_C;
        else if (k <= 2*n + 1)  return SEG_D;
        else if (k == 2*n + 2)  return SEG_E;
        else                    return SEG_F;
    endfunction

    // Digit owning ring position k (digit 0 is rightmost).
    function automatic int digit_of(input int k, input int n);
        if (k < n)              return n - 1 - k;
        else if (k <= n + 1)    return 0;
        else if (k <= 2*n + 1)  return k - n - 2;
        else                    return n - 1;
    endfunction

endpackage

// File: rtl/snake_path_decoder.sv
// Combinational lit-mask decoder: which segments of one digit
// belong to the snake body for a given head and direction.
module snake_path_decoder
    import snake_display_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SNAKE_LEN = 3,
    parameter int HEAD_W    = 5,
    parameter int DIGIT_W   = 3
) (
    input  logic [HEAD_W-1:0]  i_head,
    input  logic               i_cur_dir,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_mask
);

    localparam int P = path_len(N_DIGITS);

    // Walk the ring; a position is lit when its distance behind the
    // head (against the travel direction) is below the snake length.
    always_comb begin : decode_ring
        automatic int h = 0;
        automatic int d = 0;
        automatic logic [2:0] s = 3'd0;
        o_mask = 7'd0;
        h = int'(i_head);
        for (int k = 0; k < P; k++) begin
            d = i_cur_dir ? (h - k) : (k - h);
            if (d < 0) begin
                d = d + P;
            end
            s = 3'(seg_of(k, N_DIGITS));
            if ((d < SNAKE_LEN) &&
                (int'(i_digit) == digit_of(k, N_DIGITS))) begin
                o_mask[s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_display_multi.sv
// Snake running around the outer ring of an N-digit multiplexed
// 7-segment display, with its own anode scan and step prescaler.
module snake_display_multi
    import snake_display_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int SNAKE_LEN  = 3,
    parameter int STEP_WIDTH = 24,
    parameter int SCAN_WIDTH = 16
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    enable,
    input  logic                                    dir,
    input  logic [1:0]                              speed,
    output logic                                    seg_a,
    output logic                                    seg_b,
    output logic                                    seg_c,
    output logic                                    seg_d,
    output logic                                    seg_e,
    output logic                                    seg_f,
    output logic                                    seg_g,
    output logic [N_DIGITS-1:0]                     anodes,
    output logic [clog2(path_len(N_DIGITS))-1:0]    head
);

    localparam int P       = path_len(N_DIGITS);
    localparam int HEAD_W  = clog2(P);
    localparam int DIGIT_W = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;

    localparam logic [HEAD_W-1:0]     H_ONE   = HEAD_W'(1);
    localparam logic [HEAD_W-1:0]     H_LAST  = HEAD_W'(P - 1);
    localparam logic [HEAD_W-1:0]     H_RESET = HEAD_W'(SNAKE_LEN - 1);
    localparam logic [HEAD_W:0]       X_P     = (HEAD_W+1)'(P);
    localparam logic [HEAD_W:0]       X_LEN   = (HEAD_W+1)'(SNAKE_LEN);
    localparam logic [HEAD_W:0]       X_PMLEN = (HEAD_W+1)'(P - SNAKE_LEN);
    localparam logic [DIGIT_W-1:0]    D_ONE   = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0]    D_LAST  = DIGIT_W'(N_DIGITS - 1);
    localparam logic [STEP_WIDTH-1:0] S_ONE   = STEP_WIDTH'(1);
    localparam logic [SCAN_WIDTH-1:0] C_ONE   = SCAN_WIDTH'(1);

    logic [HEAD_W-1:0]     r_head;
    logic                  r_cur_dir;
    logic [STEP_WIDTH-1:0] r_step_cnt;
    logic [SCAN_WIDTH-1:0] r_scan_cnt;
    logic [DIGIT_W-1:0]    r_digit;
    logic [6:0]            r_seg;
    logic [N_DIGITS-1:0]   r_anodes;

    logic [STEP_WIDTH-1:0] w_step_mask;
    logic                  w_strobe;
    logic [HEAD_W-1:0]     w_head_inc;
    logic [HEAD_W-1:0]     w_head_dec;
    logic [HEAD_W:0]       w_rev_sum;
    logic [HEAD_W-1:0]     w_rev_head;
    logic [6:0]            w_mask;
    logic [N_DIGITS-1:0]   w_digit_hot;

    // Faster speeds shorten the run of low bits that must be all ones.
    assign w_step_mask = {STEP_WIDTH{1'b1}} >> speed;
    assign w_strobe    = enable &&
                         ((r_step_cnt & w_step_mask) == w_step_mask);

    assign w_head_inc = (r_head == H_LAST) ? '0 : r_head + H_ONE;
    assign w_head_dec = (r_head == '0) ? H_LAST : r_head - H_ONE;

    // Reversal jumps the head to one past the old tail, i.e. head -/+ LEN.
    assign w_rev_sum  = r_cur_dir ? ({1'b0, r_head} + X_PMLEN)
                                  : ({1'b0, r_head} + X_LEN);
    assign w_rev_head = (w_rev_sum >= X_P) ? HEAD_W'(w_rev_sum - X_P)
                                           : w_rev_sum[HEAD_W-1:0];

    snake_path_decoder #(
        .N_DIGITS  (N_DIGITS),
        .SNAKE_LEN (SNAKE_LEN),
        .HEAD_W    (HEAD_W),
        .DIGIT_W   (DIGIT_W)
    ) u_decoder (
        .i_head    (r_head),
        .i_cur_dir (r_cur_dir),
        .i_digit   (r_digit),
        .o_mask    (w_mask)
    );

    // One-hot of the digit being scanned.
    always_comb begin
        w_digit_hot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_digit_hot[i] = (r_digit == DIGIT_W'(i));
        end
    end

    // Step prescaler, frozen while the snake is paused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_cnt <= '0;
        end else if (enable) begin
            r_step_cnt <= r_step_cnt + S_ONE;
        end
    end

    // Head and direction: advance, or reverse from the old tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head    <= H_RESET;
            r_cur_dir <= 1'b1;
        end else if (w_strobe) begin
            if (dir == r_cur_dir) begin
                r_head <= dir ? w_head_inc : w_head_dec;
            end else begin
                r_head    <= w_rev_head;
                r_cur_dir <= dir;
            end
        end
    end

    // Free-running scan; digit advances each time the counter wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + C_ONE;
            if (&r_scan_cnt) begin
                r_digit <= (r_digit == D_LAST) ? '0 : r_digit + D_ONE;
            end
        end
    end

    // Active-low output registers; dark while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg    <= '1;
            r_anodes <= '1;
        end else begin
            r_seg    <= ~w_mask;
            r_anodes <= ~w_digit_hot;
        end
    end

    assign seg_a  = r_seg[SEG_A];
    assign seg_b  = r_seg[SEG_B];
    assign seg_c  = r_seg[SEG_C];
    assign seg_d  = r_seg[SEG_D];
    assign seg_e  = r_seg[SEG_E];
    assign seg_f  = r_seg[SEG_F];
    assign seg_g  = r_seg[SEG_G];
    assign anodes = r_anodes;
    assign head   = r_head;

endmodule

// File: tb/tb_snake_display_multi.sv
// Directed bench for snake_display_multi on a 2-digit, length-3 snake.
// Segment vectors are {a..g}, active-low.
module tb_snake_display_multi;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       dir;
    logic [1:0] speed;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [1:0] anodes;
    logic [2:0] head;
    logic [6:0] w_seg;

    int n_cmp;
    int n_err;

    assign w_seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

    snake_display_multi #(
        .N_DIGITS   (2),
        .SNAKE_LEN  (3),
        .STEP_WIDTH (4),
        .SCAN_WIDTH (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .dir     (dir),
        .speed   (speed),
        .seg_a   (seg_a),
        .seg_b   (seg_b),
        .seg_c   (seg_c),
        .seg_d   (seg_d),
        .seg_e   (seg_e),
        .seg_f   (seg_f),
        .seg_g   (seg_g),
        .anodes  (anodes),
        .head    (head)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Collect both digits over four scan cycles (snake must be frozen).
    task automatic snap(output logic [6:0] d0, output logic [6:0] d1);
        d0 = 'x;
        d1 = 'x;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (anodes == 2'b10) d0 = w_seg;
            else if (anodes == 2'b01) d1 = w_seg;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        dir     = 1'b1;
        speed   = 2'd0;
        ticks(3);
        n_cmp++;
        if ({w_seg, anodes} !== 9'h1FF) begin
            n_err++;
            $display("FAIL reset_dark got %b req %b",
                     {w_seg, anodes}, 9'h1FF);
        end
        n_cmp++;
        if (head !== 3'd2) begin
            n_err++;
            $display("FAIL reset_head got %0d req 2", head);
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({w_seg, anodes} !== {7'b0011111, 2'b10}) begin
            n_err++;
            $display("FAIL first_digit0 got %b req %b",
                     {w_seg, anodes}, {7'b0011111, 2'b10});
        end
        ticks(2);
        n_cmp++;
        if ({w_seg, anodes} !== {7'b0111111, 2'b01}) begin
            n_err++;
            $display("FAIL first_digit1 got %b req %b",
                     {w_seg, anodes}, {7'b0111111, 2'b01});
        end
    endtask

    task automatic test_step();
        logic [6:0] d0, d1;
        enable = 1'b1;
        ticks(15);
        n_cmp++;
        if (head !== 3'd2) begin
            n_err++;
            $display("FAIL step_early got %0d req 2", head);
        end
        tick();
        n_cmp++;
        if (head !== 3'd3) begin
            n_err++;
            $display("FAIL step_head got %0d req 3", head);
        end
        enable = 1'b0;
        snap(d0, d1);
        n_cmp++;
        if ({d0, d1} !== {7'b0001111, 7'b1111111}) begin
            n_err++;
            $display("FAIL step_segs got %b_%b req 0001111_1111111",
                     d0, d1);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] d0, d1;
        logic [2:0] exp_seq [5];
        exp_seq = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ticks(16);
            n_cmp++;
            if (head !== exp_seq[i]) begin
                n_err++;
                $display("FAIL wrap_head[%0d] got %0d req %0d",
                         i, head, exp_seq[i]);
            end
        end
        enable = 1'b0;
        snap(d0, d1);
        n_cmp++;
        if ({d0, d1} !== {7'b1111111, 7'b0111001}) begin
            n_err++;
            $display("FAIL wrap_segs got %b_%b req 1111111_0111001",
                     d0, d1);
        end
    endtask

    task automatic test_reversal();
        logic [6:0] d0, d1;
        enable = 1'b1;
        ticks(64);
        n_cmp++;
        if (head !== 3'd4) begin
            n_err++;
            $display("FAIL rev_setup got %0d req 4", head);
        end
        dir = 1'b0;
        ticks(16);
        n_cmp++;
        if (head !== 3'd1) begin
            n_err++;
            $display("FAIL rev_head got %0d req 1", head);
        end
        enable = 1'b0;
        snap(d0, d1);
        n_cmp++;
        if ({d0, d1} !== {7'b0001111, 7'b1111111}) begin
            n_err++;
            $display("FAIL rev_segs got %b_%b req 0001111_1111111",
                     d0, d1);
        end
        enable = 1'b1;
        ticks(16);
        n_cmp++;
        if (head !== 3'd0) begin
            n_err++;
            $display("FAIL ccw_step got %0d req 0", head);
        end
        ticks(16);
        n_cmp++;
        if (head !== 3'd7) begin
            n_err++;
            $display("FAIL ccw_wrap got %0d req 7", head);
        end
        enable = 1'b0;
    endtask

    task automatic test_pause_speed();
        logic [1:0] prev;
        int         changes;
        dir     = 1'b1;
        changes = 0;
        prev    = anodes;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (anodes != prev) changes++;
            prev = anodes;
        end
        n_cmp++;
        if (head !== 3'd7) begin
            n_err++;
            $display("FAIL pause_head got %0d req 7", head);
        end
        n_cmp++;
        if (changes !== 50) begin
            n_err++;
            $display("FAIL pause_scan got %0d req 50", changes);
        end
        dir    = 1'b0;
        speed  = 2'd2;
        enable = 1'b1;
        ticks(3);
        n_cmp++;
        if (head !== 3'd7) begin
            n_err++;
            $display("FAIL speed_early got %0d req 7", head);
        end
        tick();
        n_cmp++;
        if (head !== 3'd6) begin
            n_err++;
            $display("FAIL speed_step1 got %0d req 6", head);
        end
        ticks(4);
        n_cmp++;
        if (head !== 3'd5) begin
            n_err++;
            $display("FAIL speed_step2 got %0d req 5", head);
        end
    endtask

    task automatic test_reset_mid();
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({w_seg, anodes, head} !== {9'h1FF, 3'd2}) begin
            n_err++;
            $display("FAIL async_reset got %b req %b",
                     {w_seg, anodes, head}, {9'h1FF, 3'd2});
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        speed   = 2'd0;
        dir     = 1'b1;
        ticks(15);
        n_cmp++;
        if (head !== 3'd2) begin
            n_err++;
            $display("FAIL post_reset_hold got %0d req 2", head);
        end
        tick();
        n_cmp++;
        if (head !== 3'd3) begin
            n_err++;
            $display("FAIL post_reset_cw got %0d req 3", head);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_step();
        test_wrap();
        test_reversal();
        test_pause_speed();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
